toy_fanout_q: RTL and testbench
===============================

Name: toy_fanout_q

Overview:
Queued, parametrised successor to the LSU load/store fanout stage. It sits between the AGU output and the cache/store-buffer interfaces.
- Steers each AGU request by its opcode bit into a load queue or a store queue.
- Gates acceptance on the hazard flag and on the occupancy of the target queue.
- Drains each queue with its own valid/ready handshake.
- Emits a hazard-enable pulse on every load handed to the cache.
A synchronous flush empties both queues for pipeline redirect.

Parameters:
PLD_W, 64, payload width in bits (packed agu_pkg width).
OPC_BIT, 0, bit index of mem_req_opcode within s_pld; 1 = store, 0 = load.
LD_DEPTH, 4, load queue entries; power of 2, >= 2.
ST_DEPTH, 4, store queue entries; power of 2, >= 2.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous clear of both queues.
s_vld  in  1  AGU request valid.
s_rdy  out  1  AGU request ready.
s_pld  in  PLD_W  AGU request payload.
hazard_flag  in  1  1 = hazard pending; blocks acceptance.
m_load_vld  out  1  load queue head valid (to cache).
m_load_rdy  in  1  cache accepts load.
m_load_pld  out  PLD_W  load queue head payload.
m_hazard_en  out  1  load handshake pulse to hazard tracker.
m_store_vld  out  1  store queue head valid.
m_store_rdy  in  1  store buffer accepts store.
m_store_pld  out  PLD_W  store queue head payload.
ld_cnt  out  $clog2(LD_DEPTH+1)  load queue occupancy.
st_cnt  out  $clog2(ST_DEPTH+1)  store queue occupancy.

Behaviour:
- Target selection: is_st = s_pld[OPC_BIT].
- s_rdy = ~hazard_flag & ~flush & (is_st ? ~st_full : ~ld_full). This is combinational, and ready may depend on payload.
- Push: s_vld & s_rdy writes s_pld into the target queue tail. Only one queue is written per cycle.
- Each queue is a circular buffer.
  - Read/write pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH-1 -> 0.
  - Occupancy is held in a separate count register.
- Latency: an accepted request appears at m_*_vld the following cycle at the earliest. There is no same-cycle bypass.
- m_*_vld = (cnt != 0). m_*_pld is the head entry and is don't-care while vld = 0.
- Pop: m_*_vld & m_*_rdy advances the head pointer.
- m_hazard_en = m_load_vld & m_load_rdy. It is combinational and asserts exactly once per load transferred.
- Simultaneous push and pop on the same queue: the count is unchanged and both pointers advance.
- Full queue: push is refused (s_rdy = 0 for that target) even if a pop occurs in the same cycle. There is no full-pass-through.
- Empty queue: pop is impossible because vld = 0.
- Ordering: strict FIFO within each queue. There is no ordering guarantee between the load and store queues.
- hazard_flag affects acceptance only. Queued entries keep draining while it is high.
- flush:
  - Next cycle, both counts and all pointers are 0.
  - Flush overrides any same-cycle push or pop.
  - A pop handshake in the flush cycle is still honoured by the consumer side, including m_hazard_en, but the queue state is cleared regardless.
- Reset (async assert, sync-released by the top level):
  - Pointers, counts, m_load_vld, m_store_vld and m_hazard_en are 0.
  - s_rdy = ~hazard_flag immediately after reset.
  - Storage array is not reset.
- Reset mid-operation: all queued entries are discarded and no pulse is generated.

Test Plan:
- Reset then single load (OPC=0, pld=0x11), m_load_rdy=1 -> s_rdy=1. Next cycle m_load_vld=1, m_load_pld=0x11, m_hazard_en=1 for 1 cycle, ld_cnt back to 0.
- 4 stores (0xA0..0xA3) with m_store_rdy=0 -> st_cnt=4. 5th store sees s_rdy=0 while a load is still accepted (s_rdy=1). Release m_store_rdy -> A0..A3 drain in order.
- hazard_flag=1 with loads queued -> s_rdy=0, no push. Queued loads still drain with m_hazard_en pulses. Deassert hazard_flag -> acceptance resumes the same cycle.
- Full load queue with simultaneous m_load_rdy=1 and a new load -> new load refused, ld_cnt=3. Next cycle it is accepted, and 20 load push/pop cycles wrap the pointers with data intact.
- flush with ld_cnt=2, st_cnt=3 and s_vld=1 -> s_rdy=0 that cycle. Next cycle both counts are 0 and both vld are 0.
- Assert rst_n=0 mid-stream with both queues partly full -> outputs go to 0 asynchronously. After release, no stale entries appear.

Source files
------------

// File: rtl/toy_fanout_q_if.sv
// AGU-to-LSU fanout bus: request side, load/store drain handshakes and occupancy.
// slave is the fanout stage's view, master is the view of whatever drives it.
interface toy_fanout_q_if #(
  parameter int unsigned PLD_W    = 64,
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned ST_DEPTH = 4
);
  localparam int unsigned LD_CW = $clog2(LD_DEPTH + 1);
  localparam int unsigned ST_CW = $clog2(ST_DEPTH + 1);

  logic             flush;
  logic             hazard_flag;
  logic             s_vld;
  logic             s_rdy;
  logic [PLD_W-1:0] s_pld;
  logic             m_load_vld;
  logic             m_load_rdy;
  logic [PLD_W-1:0] m_load_pld;
  logic             m_hazard_en;
  logic             m_store_vld;
  logic             m_store_rdy;
  logic [PLD_W-1:0] m_store_pld;
  logic [LD_CW-1:0] ld_cnt;
  logic [ST_CW-1:0] st_cnt;

  modport slave (
    input  flush, hazard_flag, s_vld, s_pld, m_load_rdy, m_store_rdy,
    output s_rdy, m_load_vld, m_load_pld, m_hazard_en,
           m_store_vld, m_store_pld, ld_cnt, st_cnt
  );

  modport master (
    output flush, hazard_flag, s_vld, s_pld, m_load_rdy, m_store_rdy,
    input  s_rdy, m_load_vld, m_load_pld, m_hazard_en,
           m_store_vld, m_store_pld, ld_cnt, st_cnt
  );
endinterface

// File: rtl/toy_fanout_q.sv
// LSU fanout stage: steers AGU requests by opcode bit into a load queue or a
// store queue, each drained by its own valid/ready handshake.
module toy_fanout_q #(
  parameter int unsigned PLD_W    = 64,
  parameter int unsigned OPC_BIT  = 0,
  parameter int unsigned LD_DEPTH = 4,
  parameter int unsigned ST_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  toy_fanout_q_if.slave bus
);
  localparam int unsigned LD_PW = $clog2(LD_DEPTH);
  localparam int unsigned ST_PW = $clog2(ST_DEPTH);
  localparam int unsigned LD_CW = $clog2(LD_DEPTH + 1);
  localparam int unsigned ST_CW = $clog2(ST_DEPTH + 1);

  logic [PLD_W-1:0] ld_mem [LD_DEPTH];
  logic [PLD_W-1:0] st_mem [ST_DEPTH];

  logic [LD_PW-1:0] ld_wp_q, ld_rp_q;
  logic [ST_PW-1:0] st_wp_q, st_rp_q;
  logic [LD_CW-1:0] ld_cnt_q;
  logic [ST_CW-1:0] st_cnt_q;

  logic is_st;
  logic ld_full, st_full;
  logic ld_vld, st_vld;
  logic accept;
  logic ld_push, st_push;
  logic ld_pop, st_pop;

  // Acceptance depends on the payload's opcode bit, so ready is combinational.
  always_comb begin
    is_st   = bus.s_pld[OPC_BIT];
    ld_full = (ld_cnt_q == LD_CW'(LD_DEPTH));
    st_full = (st_cnt_q == ST_CW'(ST_DEPTH));
    ld_vld  = (ld_cnt_q != '0);
    st_vld  = (st_cnt_q != '0);
    accept  = ~bus.hazard_flag & ~bus.flush & (is_st ? ~st_full : ~ld_full);
    ld_push = bus.s_vld & accept & ~is_st;
    st_push = bus.s_vld & accept & is_st;
    ld_pop  = ld_vld & bus.m_load_rdy;
    st_pop  = st_vld & bus.m_store_rdy;
  end

  assign bus.s_rdy       = accept;
  assign bus.m_load_vld  = ld_vld;
  assign bus.m_store_vld = st_vld;
  assign bus.m_load_pld  = ld_mem[ld_rp_q];
  assign bus.m_store_pld = st_mem[st_rp_q];
  assign bus.m_hazard_en = ld_pop;
  assign bus.ld_cnt      = ld_cnt_q;
  assign bus.st_cnt      = st_cnt_q;

  // Storage is deliberately left unreset; count gates every read.
  always_ff @(posedge clk) begin
    if (ld_push) ld_mem[ld_wp_q] <= bus.s_pld;
    if (st_push) st_mem[st_wp_q] <= bus.s_pld;
  end

  // Load queue pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_wp_q  <= '0;
      ld_rp_q  <= '0;
      ld_cnt_q <= '0;
    end else if (bus.flush) begin
      ld_wp_q  <= '0;
      ld_rp_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      if (ld_push) ld_wp_q <= ld_wp_q + LD_PW'(1);
      if (ld_pop)  ld_rp_q <= ld_rp_q + LD_PW'(1);
      case ({ld_push, ld_pop})
        2'b10:   ld_cnt_q <= ld_cnt_q + LD_CW'(1);
        2'b01:   ld_cnt_q <= ld_cnt_q - LD_CW'(1);
        default: ld_cnt_q <= ld_cnt_q;
      endcase
    end
  end

  // Store queue pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_wp_q  <= '0;
      st_rp_q  <= '0;
      st_cnt_q <= '0;
    end else if (bus.flush) begin
      st_wp_q  <= '0;
      st_rp_q  <= '0;
      st_cnt_q <= '0;
    end else begin
      if (st_push) st_wp_q <= st_wp_q + ST_PW'(1);
      if (st_pop)  st_rp_q <= st_rp_q + ST_PW'(1);
      case ({st_push, st_pop})
        2'b10:   st_cnt_q <= st_cnt_q + ST_CW'(1);
        2'b01:   st_cnt_q <= st_cnt_q - ST_CW'(1);
        default: st_cnt_q <= st_cnt_q;
      endcase
    end
  end
endmodule

// File: tb/tb_toy_fanout_q.sv
// Scoreboard bench for toy_fanout_q: the driver queues expected drain payloads,
// a negedge monitor pops and compares them on every load/store handshake.
module tb_toy_fanout_q;
  logic clk;
  logic rst_n;

  toy_fanout_q_if #(.PLD_W(64), .LD_DEPTH(4), .ST_DEPTH(4)) bus ();

  toy_fanout_q #(.PLD_W(64), .OPC_BIT(0), .LD_DEPTH(4), .ST_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] ld_exp[$];
  logic [63:0] st_exp[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode sits in bit 0, the tag value above it.
  function automatic logic [63:0] mk(input logic [7:0] v, input logic opc);
    return {55'd0, v, opc};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] v, input logic opc, input logic exp_rdy);
    bus.s_vld = 1'b1;
    bus.s_pld = mk(v, opc);
    @(negedge clk);
    chk("s_rdy", 64'(bus.s_rdy), 64'(exp_rdy));
    @(posedge clk);
    if (exp_rdy) begin
      if (opc) st_exp.push_back(mk(v, opc));
      else     ld_exp.push_back(mk(v, opc));
    end
    #1;
    bus.s_vld = 1'b0;
  endtask

  // Monitor: valid must follow the model occupancy; every handshake pops the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_load_vld", 64'(bus.m_load_vld), 64'(ld_exp.size() != 0));
      chk("m_store_vld", 64'(bus.m_store_vld), 64'(st_exp.size() != 0));
      chk("m_hazard_en", 64'(bus.m_hazard_en), 64'((ld_exp.size() != 0) && bus.m_load_rdy));
      if (bus.m_load_vld && bus.m_load_rdy) begin
        if (ld_exp.size() == 0) chk("load_unexpected", bus.m_load_pld, 64'hDEAD);
        else                    chk("load_pld", bus.m_load_pld, ld_exp.pop_front());
      end
      if (bus.m_store_vld && bus.m_store_rdy) begin
        if (st_exp.size() == 0) chk("store_unexpected", bus.m_store_pld, 64'hDEAD);
        else                    chk("store_pld", bus.m_store_pld, st_exp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.flush        = 1'b0;
    bus.hazard_flag  = 1'b0;
    bus.s_vld        = 1'b0;
    bus.s_pld        = '0;
    bus.m_load_rdy   = 1'b0;
    bus.m_store_rdy  = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    chk("rst_s_rdy", 64'(bus.s_rdy), 64'd1);
    chk("rst_ld_cnt", 64'(bus.ld_cnt), 64'd0);
    chk("rst_st_cnt", 64'(bus.st_cnt), 64'd0);
    chk("rst_hazard_en", 64'(bus.m_hazard_en), 64'd0);

    // Single load drains next cycle with one hazard pulse
    bus.m_load_rdy = 1'b1;
    offer(8'h11, 1'b0, 1'b1);
    chk("single_ld_cnt", 64'(bus.ld_cnt), 64'd1);
    idle(1);
    chk("single_ld_cnt_after", 64'(bus.ld_cnt), 64'd0);

    // Fill store queue, fifth store refused while a load is accepted
    for (int i = 0; i < 4; i++) offer(8'hA0 + 8'(i), 1'b1, 1'b1);
    chk("st_full_cnt", 64'(bus.st_cnt), 64'd4);
    offer(8'hA4, 1'b1, 1'b0);
    offer(8'h22, 1'b0, 1'b1);
    bus.m_store_rdy = 1'b1;
    idle(6);
    chk("st_drain_cnt", 64'(bus.st_cnt), 64'd0);

    // Hazard blocks acceptance but not draining
    bus.m_load_rdy = 1'b0;
    offer(8'h30, 1'b0, 1'b1);
    offer(8'h31, 1'b0, 1'b1);
    bus.hazard_flag = 1'b1;
    offer(8'h32, 1'b0, 1'b0);
    offer(8'hB2, 1'b1, 1'b0);
    bus.m_load_rdy = 1'b1;
    idle(3);
    chk("hz_drain_cnt", 64'(bus.ld_cnt), 64'd0);
    bus.hazard_flag = 1'b0;
    offer(8'h33, 1'b0, 1'b1);
    idle(2);

    // Full load queue refuses a push even with a same-cycle pop
    bus.m_load_rdy = 1'b0;
    for (int i = 0; i < 4; i++) offer(8'h40 + 8'(i), 1'b0, 1'b1);
    chk("ld_full_cnt", 64'(bus.ld_cnt), 64'd4);
    bus.m_load_rdy = 1'b1;
    offer(8'h44, 1'b0, 1'b0);
    chk("ld_after_pop_cnt", 64'(bus.ld_cnt), 64'd3);
    offer(8'h44, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) offer(8'h50 + 8'(i), 1'b0, 1'b1);
    chk("ld_steady_cnt", 64'(bus.ld_cnt), 64'd3);
    idle(6);
    chk("ld_wrap_drain_cnt", 64'(bus.ld_cnt), 64'd0);

    // Flush clears both queues and blocks acceptance in its cycle
    bus.m_load_rdy  = 1'b0;
    bus.m_store_rdy = 1'b0;
    offer(8'h60, 1'b0, 1'b1);
    offer(8'h61, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) offer(8'hC0 + 8'(i), 1'b1, 1'b1);
    chk("pre_flush_ld", 64'(bus.ld_cnt), 64'd2);
    chk("pre_flush_st", 64'(bus.st_cnt), 64'd3);
    bus.flush = 1'b1;
    bus.s_vld = 1'b1;
    bus.s_pld = mk(8'h62, 1'b0);
    @(negedge clk);
    chk("flush_s_rdy", 64'(bus.s_rdy), 64'd0);
    @(posedge clk);
    ld_exp.delete();
    st_exp.delete();
    #1;
    bus.flush = 1'b0;
    bus.s_vld = 1'b0;
    chk("flush_ld_cnt", 64'(bus.ld_cnt), 64'd0);
    chk("flush_st_cnt", 64'(bus.st_cnt), 64'd0);
    bus.m_load_rdy  = 1'b1;
    bus.m_store_rdy = 1'b1;
    idle(2);
    offer(8'h70, 1'b0, 1'b1);
    offer(8'hD0, 1'b1, 1'b1);
    idle(3);

    // Async reset mid-stream discards queued entries
    bus.m_load_rdy  = 1'b0;
    bus.m_store_rdy = 1'b0;
    offer(8'h80, 1'b0, 1'b1);
    offer(8'h81, 1'b0, 1'b1);
    offer(8'hE0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    ld_exp.delete();
    st_exp.delete();
    #1;
    chk("arst_ld_vld", 64'(bus.m_load_vld), 64'd0);
    chk("arst_st_vld", 64'(bus.m_store_vld), 64'd0);
    chk("arst_ld_cnt", 64'(bus.ld_cnt), 64'd0);
    chk("arst_st_cnt", 64'(bus.st_cnt), 64'd0);
    bus.m_load_rdy = 1'b1;
    chk("arst_hazard_en", 64'(bus.m_hazard_en), 64'd0);
    bus.hazard_flag = 1'b1;
    #1;
    chk("arst_s_rdy_hz", 64'(bus.s_rdy), 64'd0);
    bus.hazard_flag = 1'b0;
    #1;
    chk("arst_s_rdy", 64'(bus.s_rdy), 64'd1);
    idle(2);
    rst_n = 1'b1;
    bus.m_store_rdy = 1'b1;
    idle(4);
    chk("post_rst_ld_cnt", 64'(bus.ld_cnt), 64'd0);
    offer(8'h90, 1'b0, 1'b1);
    idle(3);
    chk("end_ld_model_empty", 64'(ld_exp.size()), 64'd0);
    chk("end_st_model_empty", 64'(st_exp.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
